// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks onto the single regfile write port; 1-cycle grant-to-write, LSU priority.
// Readies are combinational and low under wb_stall or reset; define ARB_STARVE_EN for ALU starvation promotion.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            write_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] data_in,
  output logic [4:0]      bypass_rd,
  output logic [XLEN-1:0] bypass_res
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic promote;

`ifdef ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign promote = alu_valid && (starve_cnt == CNT_MAX);

  // Counts only cycles the ALU was refused while arbitration was live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_ready) begin
      starve_cnt <= '0;
    end else if (alu_valid && !wb_stall && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // No starvation counter: LSU always outranks the ALU.
  assign promote = (STARVE_LIMIT < 0);
`endif

  assign lsu_ready = rst_n && !wb_stall && lsu_valid && !promote;
  assign alu_ready = rst_n && !wb_stall && alu_valid && !lsu_ready;

  wb_t win;
  always_comb begin
    win = '0;
    if (lsu_ready) begin
      win.rd   = lsu_rd;
      win.data = lsu_data;
    end else if (alu_ready) begin
      win.rd   = alu_rd;
      win.data = alu_data;
    end
  end

  wb_t  wb_q;
  logic we_q;

  // An x0 write consumes the slot but leaves the port and bypass all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      wb_q <= '0;
    end else begin
      we_q <= (win.rd != 5'd0);
      wb_q <= (win.rd != 5'd0) ? win : '0;
    end
  end

  assign write_en   = we_q;
  assign rd_addr    = wb_q.rd;
  assign data_in    = wb_q.data;
  assign bypass_rd  = wb_q.rd;
  assign bypass_res = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;
`ifdef ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, wb_stall;
  logic            alu_valid, lsu_valid;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            alu_ready, lsu_ready, write_en;
  logic [4:0]      rd_addr, bypass_rd;
  logic [XLEN-1:0] data_in, bypass_res;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .write_en(write_en), .rd_addr(rd_addr), .data_in(data_in),
    .bypass_rd(bypass_rd), .bypass_res(bypass_res)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the write port should show, and ALU denial run length.
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  int              m_cnt;

  wire [74:0] obs = {write_en, rd_addr, data_in, bypass_rd, bypass_res};

  function automatic logic [74:0] exp_vec();
    return {m_we, m_rd, m_data, m_rd, m_data};
  endfunction

  // {alu_ready, lsu_ready} from the arbitration rules.
  function automatic logic [1:0] model_ready();
    logic alu_first, lr, ar;
    alu_first = STARVE && alu_valid && (m_cnt == LIM);
    lr = rst_n && !wb_stall && lsu_valid && !alu_first;
    ar = rst_n && !wb_stall && alu_valid && !lr;
    return {ar, lr};
  endfunction

  function automatic void model_reset();
    m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
  endfunction

  // Advance the model across one rising edge, then settle 1 time unit past it.
  task automatic tick();
    logic [1:0] r;
    logic [4:0] rd;
    logic [XLEN-1:0] d;
    r = model_ready();
    rd = '0; d = '0;
    if (r[0]) begin rd = lsu_rd; d = lsu_data; end
    else if (r[1]) begin rd = alu_rd; d = alu_data; end
    if (r[1]) m_cnt = 0;
    else if (alu_valid && !wb_stall && m_cnt < LIM) m_cnt = m_cnt + 1;
    @(posedge clk);
    m_we   = (rd != 0);
    m_rd   = (rd != 0) ? rd : 5'd0;
    m_data = (rd != 0) ? d : '0;
    #1;
  endtask

  task automatic idle_inputs();
    wb_stall = 0; alu_valid = 0; lsu_valid = 0;
    alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d;
    rst_n = 0; idle_inputs(); model_reset();
    alu_valid = 1; lsu_valid = 1; alu_rd = 5'd9; lsu_rd = 5'd10;
    #2;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin errors++;
      $display("FAIL reset_ready: got %b want 00", {alu_ready, lsu_ready}); end
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL reset_out: got %h want 0", obs); end
    @(negedge clk); rst_n = 1; idle_inputs();
    d = $urandom;
    @(negedge clk); alu_valid = 1; alu_rd = 5'd7; alu_data = d;
    #1;
    tick();
    checks++;
    if (obs !== {1'b1, 5'd7, d, 5'd7, d}) begin errors++;
      $display("FAIL pre_reset_write: got %h want %h", obs, {1'b1, 5'd7, d, 5'd7, d}); end
    #2; rst_n = 0; model_reset();
    #1;
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL midop_reset_out: got %h want 0", obs); end
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin errors++;
      $display("FAIL midop_reset_ready: got %b want 00", {alu_ready, lsu_ready}); end
    @(negedge clk); idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_alu_single();
    @(negedge clk); alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin errors++;
      $display("FAIL alu_single_ready: got %b want 10", {alu_ready, lsu_ready}); end
    tick();
    checks++;
    if (obs !== {1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF}) begin errors++;
      $display("FAIL alu_single_out: got %h want %h", obs, {1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF}); end
    @(negedge clk); alu_valid = 0;
    #1; tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL alu_single_idle: got %h want 0", obs); end
  endtask

  task automatic test_both_valid();
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h11;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h22;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b01) begin errors++;
      $display("FAIL both_c0_ready: got %b want 01", {alu_ready, lsu_ready}); end
    tick();
    checks++;
    if (obs !== {1'b1, 5'd3, 32'h11, 5'd3, 32'h11}) begin errors++;
      $display("FAIL both_c0_out: got %h want rd3/11", obs); end
    @(negedge clk); lsu_valid = 0;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin errors++;
      $display("FAIL both_c1_ready: got %b want 10", {alu_ready, lsu_ready}); end
    tick();
    checks++;
    if (obs !== {1'b1, 5'd4, 32'h22, 5'd4, 32'h22}) begin errors++;
      $display("FAIL both_c1_out: got %h want rd4/22", obs); end
    @(negedge clk); alu_valid = 0;
  endtask

  task automatic test_rd_zero();
    @(negedge clk); lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", lsu_ready); end
    tick();
    checks++;
    if ({write_en, bypass_rd, bypass_res} !== 38'd0) begin errors++;
      $display("FAIL rd0_out: got we=%b brd=%0d bres=%h want all 0", write_en, bypass_rd, bypass_res); end
    @(negedge clk); lsu_valid = 0;
  endtask

  task automatic test_starvation();
    logic [1:0] r;
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 5'($urandom_range(1, 31)); lsu_data = $urandom;
    alu_valid = 1; alu_rd = 5'd12; alu_data = $urandom;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      r = model_ready();
      checks++;
      if ({alu_ready, lsu_ready} !== r) begin errors++;
        $display("FAIL starve_ready c%0d: got %b want %b", c, {alu_ready, lsu_ready}, r); end
      if (STARVE && (c == 4 || c == 5)) begin
        checks++;
        if ({alu_ready, lsu_ready} !== ((c == 4) ? 2'b10 : 2'b01)) begin errors++;
          $display("FAIL starve_promote c%0d: got %b", c, {alu_ready, lsu_ready}); end
      end
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++;
        $display("FAIL starve_out c%0d: got %h want %h", c, obs, exp_vec()); end
      if (r[0]) begin lsu_rd = 5'($urandom_range(1, 31)); lsu_data = $urandom; end
    end
    @(negedge clk); lsu_valid = 0;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_drain: got %b want 1", alu_ready); end
    tick();
    @(negedge clk); alu_valid = 0;
  endtask

  task automatic test_stall();
    logic [1:0] r;
    @(negedge clk);
    wb_stall = 1;
    lsu_valid = 1; lsu_rd = 5'd20; lsu_data = $urandom;
    alu_valid = 1; alu_rd = 5'd21; alu_data = $urandom;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({alu_ready, lsu_ready} !== 2'b00) begin errors++;
        $display("FAIL stall_ready c%0d: got %b want 00", c, {alu_ready, lsu_ready}); end
      tick();
      checks++;
      if (obs !== 75'd0) begin errors++; $display("FAIL stall_out c%0d: got %h want 0", c, obs); end
    end
    @(negedge clk); wb_stall = 0;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b01) begin errors++;
      $display("FAIL stall_release: got %b want 01", {alu_ready, lsu_ready}); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      r = model_ready();
      checks++;
      if ({alu_ready, lsu_ready} !== r) begin errors++;
        $display("FAIL post_stall_ready c%0d: got %b want %b", c, {alu_ready, lsu_ready}, r); end
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++;
        $display("FAIL post_stall_out c%0d: got %h want %h", c, obs, exp_vec()); end
      if (r[0]) lsu_data = $urandom;
      if (r[1]) alu_data = $urandom;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    logic [1:0] r;
    int bad_rdy, bad_out;
    bad_rdy = 0; bad_out = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      wb_stall = ($urandom_range(0, 99) < 15);
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd = 5'($urandom); alu_data = $urandom;
      end
      if (!lsu_valid) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_rd = 5'($urandom); lsu_data = $urandom;
      end
      #1;
      r = model_ready();
      checks++;
      if ({alu_ready, lsu_ready} !== r) begin errors++; bad_rdy++;
        if (bad_rdy < 5) $display("FAIL rand_ready c%0d: got %b want %b", c, {alu_ready, lsu_ready}, r); end
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; bad_out++;
        if (bad_out < 5) $display("FAIL rand_out c%0d: got %h want %h", c, obs, exp_vec()); end
      if (r[1]) alu_valid = 0;
      if (r[0]) lsu_valid = 0;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_both_valid();
    test_rd_zero();
    test_starvation();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU and the load/store unit (LSU).
- Per-source valid/ready handshake; one grant per cycle.
- Registers the winning writeback and drives the register file's write port (write_en, rd_addr, data_in) and bypass inputs (bypass_rd, bypass_res).
- Sits between execute/memory stages and the register file.

Parameters:
XLEN, 32, datapath width (matches core `XLEN)
STARVE_LIMIT, 4, consecutive ALU-denied cycles before ALU is promoted (used only with ARB_STARVE_EN)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_stall  input  1  global writeback hold; no grants while high
alu_valid  input  1  ALU writeback request
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU request accepted this cycle
lsu_valid  input  1  LSU writeback request
lsu_rd  input  5  LSU destination register
lsu_data  input  XLEN  load data
lsu_ready  output  1  LSU request accepted this cycle
write_en  output  1  register file write enable
rd_addr  output  5  register file write address
data_in  output  XLEN  register file write data
bypass_rd  output  5  register file bypass address
bypass_res  output  XLEN  register file bypass data

Behaviour:
- Reset (rst_n low, async): write_en=0, rd_addr=0, data_in=0, bypass_rd=0, bypass_res=0; starvation counter=0.
- alu_ready and lsu_ready are combinational from the valids, wb_stall and the starvation state. Both are 0 while rst_n is low.
- Sources must not make valid depend on ready. A source holds valid, rd and data stable until ready.
- Transfer occurs when valid && ready; at most one ready is high per cycle.
- Grant (base policy): if wb_stall=1, no grant. Else if lsu_valid, LSU wins. Else if alu_valid, ALU wins.
- Output stage, one cycle after grant (registered):
  - write_en=1, rd_addr=granted rd, data_in=granted data.
  - bypass_rd=rd_addr, bypass_res=data_in, both same cycle as write_en.
- No grant (including stall): next cycle write_en=0, rd_addr=0, data_in=0, bypass_rd=0, bypass_res=0.
- rd=0 requests:
  - Granted and consumed normally (ready=1) and they take the slot.
  - Next cycle write_en=0, bypass_rd=0, bypass_res=0, so x0 reads bypass to 0.
- Rule: bypass_rd nonzero only when write_en=1; bypass_res is 0 whenever bypass_rd=0.
- Same nonzero rd from both sources in one cycle:
  - Winner written first, loser one cycle later (later write persists).
  - Program-order correctness is the issue logic's responsibility.
- Throughput: one writeback per cycle sustained. Latency: grant-to-write 1 cycle.
- Reset asserted mid-operation: the pending output-stage write is discarded and the outputs clear immediately.

Optional Feature:
ARB_STARVE_EN
- Defined: a counter of width $clog2(STARVE_LIMIT+1) tracks ALU starvation.
  - Increments each cycle alu_valid && !alu_ready && !wb_stall, saturating at STARVE_LIMIT.
  - Clears on ALU grant and on reset; holds during wb_stall or while alu_valid=0.
  - When the counter == STARVE_LIMIT and alu_valid, ALU wins over LSU that cycle.
- Undefined: strict LSU-over-ALU priority; counter absent.

Test Plan:
1. Assert rst_n=0 for 1 cycle while write_en=1 (rd_addr=7) -> write_en, rd_addr, data_in, bypass_rd, bypass_res all 0 immediately; both readies 0 during reset.
2. alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, lsu_valid=0 -> alu_ready=1 same cycle; next cycle write_en=1, rd_addr=5, data_in=0xDEADBEEF, bypass_rd=5, bypass_res=0xDEADBEEF.
3. Both valid for 1 cycle (lsu_rd=3/0x11, alu_rd=4/0x22), ALU holds, no macro -> LSU granted cycle 0, ALU cycle 1; writes rd 3 then rd 4 on consecutive cycles.
4. lsu_valid=1, lsu_rd=0, lsu_data=0xFFFFFFFF -> lsu_ready=1; next cycle write_en=0, bypass_rd=0, bypass_res=0.
5. ARB_STARVE_EN, STARVE_LIMIT=4, lsu_valid held high, alu_valid high from cycle 0 -> ALU denied cycles 0-3, alu_ready=1 on cycle 4 with lsu_ready=0; LSU resumes cycle 5.
6. wb_stall=1 for 3 cycles with both valid -> both readies 0, write_en=0 from next cycle, starvation counter unchanged; stall release -> LSU granted first.
